key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Classifies debounced key events into short-press, double-click and long-press pulses.
//  Sits directly downstream of the key debouncer.
//  Consumes its 1-cycle key_flag strobe and the settled key_value (0 = pressed).
//  Feeds the ranging control logic (mode switch, trigger, display hold).
// PARAMETERS
//  CLK_FREQ    100_000_000  sys_clk frequency, Hz; CYC_PER_MS = CLK_FREQ/1000
//  LONG_MS     1000         hold time to declare a long press, ms
//  DCLICK_MS   300          max release-to-second-press gap for a double click, ms
//  REPEAT_MS   200          auto-repeat period while long-held, ms (KEY_EVT_REPEAT_EN only)
// PORTS
//  sys_clk       in   1  system clock
//  sys_rst_n     in   1  asynchronous reset, active low
//  key_flag      in   1  debounced-change strobe, 1 cycle wide
//  key_value     in   1  debounced key level, valid when key_flag=1; 0=pressed, 1=released
//  short_press   out  1  1-cycle pulse: single click confirmed
//  double_click  out  1  1-cycle pulse: second release of a double click
//  long_press    out  1  1-cycle pulse: hold reached LONG_MS
//  key_repeat    out  1  1-cycle pulse every REPEAT_MS while long-held (0 if feature off)
//  key_state     out  3  current FSM state encoding, for debug/LED
// BEHAVIOUR
//  - Reset: every output is 0; state is IDLE; ms counter and prescaler are 0.
//  - Input events:
//    - press   = key_flag & ~key_value
//    - release = key_flag &  key_value
//    - key_value is ignored when key_flag=0.
//  - Time base: prescaler counts 0..CYC_PER_MS-1 and emits ms_tick at terminal count.
//    - ms_cnt increments on ms_tick.
//    - Both prescaler and ms_cnt clear on every state transition, so timeouts are exact in cycles.
//  - FSM, with transitions taken on the event cycle:
//    - IDLE(0):  press -> PRESS1. A release is ignored.
//    - PRESS1(1): release -> WAIT2.
//        ms_cnt==LONG_MS reached -> LONG_HELD, and long_press fires.
//    - WAIT2(2): press -> PRESS2.
//        ms_cnt==DCLICK_MS reached -> IDLE, and short_press fires.
//    - PRESS2(3): release -> IDLE, and double_click fires. There is no timeout in this state.
//    - LONG_HELD(4): release -> IDLE. No further pulse fires on release.
//    - A redundant event (press while pressed, release while released) causes no transition and no counter clear.
//  - Latency: every output pulse is registered.
//    - It is high exactly 1 cycle, in the cycle after the triggering event or timeout.
//  - Long timeout fires LONG_MS*CYC_PER_MS cycles after the press event cycle.
//    - A release in that same cycle wins, and the FSM goes to WAIT2.
//  - Each gesture produces at most one of short_press, double_click or long_press.
//  - ms_cnt width = $clog2(max(LONG_MS,DCLICK_MS,REPEAT_MS)+1). ms_cnt saturates and never wraps.
//  - Async reset mid-gesture aborts it with no pulse. The next press starts from IDLE.
// CONFIGURATION
//  `KEY_EVT_REPEAT_EN defined:
//    - In LONG_HELD, key_repeat pulses every REPEAT_MS ms.
//    - The first repeat comes REPEAT_MS after long_press.
//    - ms_cnt clears after each repeat.
//  `KEY_EVT_REPEAT_EN undefined:
//    - key_repeat is tied to 0.
//    - No repeat counter logic is built.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package key_evt_pkg holds:
//    - state typedef: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG_HELD=4
//    - ms_cycles(CLK_FREQ) constant function
//    - counter width function
//  - Sub-module key_ms_tick holds the prescaler.
//    - Ports: sys_clk, sys_rst_n, clr, ms_tick.
//    - It is instantiated once.
//  - FSM, ms_cnt and output registers stay in the top.
// TESTING (bench uses CLK_FREQ=10_000 => 10 cyc/ms, LONG_MS=10, DCLICK_MS=3, REPEAT_MS=2)
//  1. Press at cycle T, release at T+20, idle.
//     -> short_press=1 only at T+20+30+1; no other pulses.
//  2. Press T, release T+20, press T+40, release T+60.
//     -> double_click=1 at T+61; short_press never fires.
//  3. Press at T, hold 200 cycles.
//     -> long_press=1 at T+101.
//     -> Release produces no pulse; state returns to IDLE.
//  4. With KEY_EVT_REPEAT_EN, press at T and hold.
//     -> key_repeat at T+121, T+141, T+161 ...
//     -> Without the macro, key_repeat stays 0.
//  5. Release alone in IDLE, or a duplicate press in PRESS1.
//     -> No transition; the timeout still lands at the original cycle.
//  6. Deassert sys_rst_n in WAIT2 at T+25.
//     -> All outputs 0 immediately; no short_press later; key_state=0.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared types and constant helpers for the key event decoder.
package key_evt_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT2     = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } key_state_t;

   function automatic int ms_cycles(input int clk_freq);
      return (clk_freq / 1000 < 1) ? 1 : clk_freq / 1000;
   endfunction

   // Bits needed to hold the largest of three values; never less than one.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_ms_tick.sv
// Millisecond prescaler: counts 0..CYC_PER_MS-1 and flags the terminal count.
module key_ms_tick
   import key_evt_pkg::*;
#(
   parameter int CYC_PER_MS = 100_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic clr,
   output logic ms_tick
);

   localparam int PW = cnt_width(CYC_PER_MS - 1, 0, 0);
   localparam logic [PW-1:0] TERM = PW'(CYC_PER_MS - 1);

   logic [PW-1:0] pre;

   assign ms_tick = (pre == TERM);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pre <= '0;
      end else if (clr || ms_tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key events into short-press, double-click and long-press pulses.
// Optional auto-repeat while long-held is built only when KEY_EVT_REPEAT_EN is defined.
module key_event_decoder
   import key_evt_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int LONG_MS   = 1000,
   parameter int DCLICK_MS = 300,
   parameter int REPEAT_MS = 200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_flag,
   input  logic       key_value,
   output logic       short_press,
   output logic       double_click,
   output logic       long_press,
   output logic       key_repeat,
   output logic [2:0] key_state
);

   localparam int CYC_PER_MS = ms_cycles(CLK_FREQ);
   localparam int CNT_W      = cnt_width(LONG_MS, DCLICK_MS, REPEAT_MS);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
   localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_MS - 1);

   key_state_t       state, state_nx;
   logic [CNT_W-1:0] ms_cnt;
   logic             press, release_evt;
   logic             ms_tick, clr;
   logic             long_hit, dclk_hit;
   logic             short_nx, dbl_nx, long_nx;

   assign press       = key_flag & ~key_value;
   assign release_evt = key_flag &  key_value;

   // A timeout is recognised on the tick that would move ms_cnt onto the limit,
   // so the registered pulse lands exactly LIMIT*CYC_PER_MS+1 cycles after entry.
   assign long_hit = ms_tick && (ms_cnt == LONG_LAST);
   assign dclk_hit = ms_tick && (ms_cnt == DCLK_LAST);

   assign clr       = (state_nx != state);
   assign key_state = state;

   key_ms_tick #(
      .CYC_PER_MS (CYC_PER_MS)
   ) u_ms_tick (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (clr),
      .ms_tick   (ms_tick)
   );

`ifdef KEY_EVT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
   logic rep_hit, rep_nx;
   assign rep_hit = (state == LONG_HELD) && ms_tick && (ms_cnt == REP_LAST);
   assign rep_nx  = rep_hit && !release_evt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_repeat <= 1'b0;
      end else begin
         key_repeat <= rep_nx;
      end
   end
`else
   logic rep_hit;
   assign rep_hit    = 1'b0;
   assign key_repeat = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      short_nx = 1'b0;
      dbl_nx   = 1'b0;
      long_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (press) state_nx = PRESS1;
         end
         PRESS1: begin
            if (release_evt) begin
               state_nx = WAIT2;
            end else if (long_hit) begin
               state_nx = LONG_HELD;
               long_nx  = 1'b1;
            end
         end
         WAIT2: begin
            if (press) begin
               state_nx = PRESS2;
            end else if (dclk_hit) begin
               state_nx = IDLE;
               short_nx = 1'b1;
            end
         end
         PRESS2: begin
            if (release_evt) begin
               state_nx = IDLE;
               dbl_nx   = 1'b1;
            end
         end
         LONG_HELD: begin
            if (release_evt) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         short_press  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
      end else begin
         state        <= state_nx;
         short_press  <= short_nx;
         double_click <= dbl_nx;
         long_press   <= long_nx;
      end
   end

   // ms_cnt restarts on every transition and after each repeat; otherwise it saturates.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ms_cnt <= '0;
      end else if (clr || rep_hit) begin
         ms_cnt <= '0;
      end else if (ms_tick && (ms_cnt != CNT_MAX)) begin
         ms_cnt <= ms_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed gestures plus random key traffic
// compared against an absolute-deadline reference model.
module tb_key_event_decoder;

   localparam int CLK_FREQ  = 10_000;
   localparam int CPM       = 10;
   localparam int LONG_MS   = 10;
   localparam int DCLICK_MS = 3;
   localparam int REPEAT_MS = 2;
`ifdef KEY_EVT_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   localparam int M_IDLE = 0, M_PRESS1 = 1, M_WAIT2 = 2, M_PRESS2 = 3, M_LONG = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       key_flag = 1'b0;
   logic       key_value = 1'b1;
   logic       short_press, double_click, long_press, key_repeat;
   logic [2:0] key_state;

   key_event_decoder #(
      .CLK_FREQ  (CLK_FREQ),
      .LONG_MS   (LONG_MS),
      .DCLICK_MS (DCLICK_MS),
      .REPEAT_MS (REPEAT_MS)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .key_flag     (key_flag),
      .key_value    (key_value),
      .short_press  (short_press),
      .double_click (double_click),
      .long_press   (long_press),
      .key_repeat   (key_repeat),
      .key_state    (key_state)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;
   int n = 0;
   int phase = M_IDLE;
   int t0 = 0;
   int rep_t = 0;
   int last_s = -1, last_d = -1, last_l = -1, first_r = -1;
   int cnt_s = 0, cnt_d = 0, cnt_l = 0, cnt_r = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, predict from deadlines, then compare after the edge.
   task automatic step(input logic f, input logic v);
      logic es, ed, el, er;
      logic pr, rl;
      es = 1'b0; ed = 1'b0; el = 1'b0; er = 1'b0;
      pr = f & ~v;
      rl = f & v;
      key_flag  = f;
      key_value = v;
      case (phase)
         M_IDLE:   if (pr) begin phase = M_PRESS1; t0 = n; end
         M_PRESS1: begin
            if (rl) begin phase = M_WAIT2; t0 = n; end
            else if (n == t0 + LONG_MS * CPM) begin
               phase = M_LONG; t0 = n; rep_t = n; el = 1'b1;
            end
         end
         M_WAIT2: begin
            if (pr) begin phase = M_PRESS2; t0 = n; end
            else if (n == t0 + DCLICK_MS * CPM) begin
               phase = M_IDLE; t0 = n; es = 1'b1;
            end
         end
         M_PRESS2: if (rl) begin phase = M_IDLE; t0 = n; ed = 1'b1; end
         default: begin
            if (rl) begin phase = M_IDLE; t0 = n; end
            else if (REP_ON && n == rep_t + REPEAT_MS * CPM) begin
               rep_t = n; er = 1'b1;
            end
         end
      endcase
      @(posedge sys_clk);
      #1;
      check("short_press", 32'(short_press), 32'(es));
      check("double_click", 32'(double_click), 32'(ed));
      check("long_press", 32'(long_press), 32'(el));
      check("key_repeat", 32'(key_repeat), 32'(er));
      check("key_state", 32'(key_state), 32'(phase));
      if (short_press === 1'b1) begin last_s = n + 1; cnt_s++; end
      if (double_click === 1'b1) begin last_d = n + 1; cnt_d++; end
      if (long_press === 1'b1) begin last_l = n + 1; cnt_l++; end
      if (key_repeat === 1'b1) begin
         if (first_r < 0) first_r = n + 1;
         cnt_r++;
      end
      n++;
   endtask

   // key_value wanders while key_flag is low; it must be ignored.
   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 1'(($urandom % 2)));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_short"}, 32'(short_press), 32'd0);
      check({tag, "_dbl"}, 32'(double_click), 32'd0);
      check({tag, "_long"}, 32'(long_press), 32'd0);
      check({tag, "_rep"}, 32'(key_repeat), 32'd0);
      check({tag, "_state"}, 32'(key_state), 32'd0);
   endtask

   initial begin
      int t;
      int s0, d0, l0, r0;

      // Power-on reset
      repeat (2) @(posedge sys_clk);
      #1;
      check_outputs_zero("rst");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      n = 0;

      // Single click: short_press release+31
      t = n; s0 = cnt_s; d0 = cnt_d; l0 = cnt_l;
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(40);
      check("t1_short_at", 32'(last_s), 32'(t + 51));
      check("t1_short_cnt", 32'(cnt_s - s0), 32'd1);
      check("t1_other_cnt", 32'(cnt_d - d0 + cnt_l - l0), 32'd0);

      // Double click
      t = n; s0 = cnt_s; d0 = cnt_d;
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(19);
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(40);
      check("t2_dbl_at", 32'(last_d), 32'(t + 61));
      check("t2_dbl_cnt", 32'(cnt_d - d0), 32'd1);
      check("t2_short_cnt", 32'(cnt_s - s0), 32'd0);

      // Long press with hold, release at T+195
      t = n; l0 = cnt_l; r0 = cnt_r; s0 = cnt_s; first_r = -1;
      step(1'b1, 1'b0); idle(194); step(1'b1, 1'b1); idle(10);
      check("t3_long_at", 32'(last_l), 32'(t + 101));
      check("t3_long_cnt", 32'(cnt_l - l0), 32'd1);
      check("t3_short_cnt", 32'(cnt_s - s0), 32'd0);
      check("t3_state_idle", 32'(key_state), 32'd0);
      if (REP_ON) begin
         check("t4_first_rep", 32'(first_r), 32'(t + 121));
         check("t4_rep_cnt", 32'(cnt_r - r0), 32'd4);
      end else begin
         check("t4_rep_cnt_off", 32'(cnt_r - r0), 32'd0);
      end

      // Release in the very cycle the long timeout lands: release wins
      t = n; l0 = cnt_l;
      step(1'b1, 1'b0); idle(99); step(1'b1, 1'b1); idle(40);
      check("t3b_long_cnt", 32'(cnt_l - l0), 32'd0);
      check("t3b_short_at", 32'(last_s), 32'(t + 131));

      // Redundant events: release in IDLE, duplicate press in PRESS1
      step(1'b1, 1'b1); idle(5);
      check("t5_idle_state", 32'(key_state), 32'd0);
      t = n;
      step(1'b1, 1'b0); idle(29); step(1'b1, 1'b0); idle(79);
      check("t5_long_at", 32'(last_l), 32'(t + 101));
      step(1'b1, 1'b1); idle(5);

      // Duplicate release in WAIT2
      t = n;
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(9); step(1'b1, 1'b1); idle(30);
      check("t5b_short_at", 32'(last_s), 32'(t + 51));

      // Async reset mid-gesture in WAIT2 at T+25
      s0 = cnt_s;
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(4);
      check("t6_pre_state", 32'(key_state), 32'd2);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check_outputs_zero("t6_rst");
      @(posedge sys_clk);
      @(posedge sys_clk);
      #4;
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      n += 3;
      phase = M_IDLE;
      idle(60);
      check("t6_no_short", 32'(cnt_s - s0), 32'd0);
      t = n;
      step(1'b1, 1'b0); idle(19); step(1'b1, 1'b1); idle(40);
      check("t6_next_short_at", 32'(last_s), 32'(t + 51));

      // Random key traffic against the model
      for (int k = 0; k < 150; k++) begin
         idle(int'($urandom_range(1, 130)));
         step(1'b1, 1'($urandom_range(0, 1)));
      end
      idle(150);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
